// File: rtl/clk_div_monitor.sv
// In-system checker for a clock divided from clk: measures each rise-to-rise period and its
// high time, locks after LOCK_CNT consecutive periods of EXP_DIV, and flags sticky faults.
module clk_div_monitor #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned EXP_DIV  = 4,
    parameter int unsigned LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             locked,
    output logic             err
);

    localparam int unsigned      MW     = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] ExpV   = CNT_W'(EXP_DIV);
    localparam logic [MW-1:0]    LockV  = MW'(LOCK_CNT);

    typedef enum logic [2:0] {StIdle, StArm, StMeasure, StLocked, StFault} state_e;

    state_e           state_q, state_d;
    logic             d_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             vld_q, vld_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [MW-1:0]    match_q, match_d;

    logic rise;
    logic timeout;
    logic cnt_ok;

    // div_in is synchronous to clk, so no synchronizer ahead of the edge detector.
    assign rise    = div_in & ~d_q;
    assign timeout = (cnt_q == CntMax);
    assign cnt_ok  = (cnt_q == ExpV);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        vld_d    = 1'b0;
        locked_d = locked_q;
        err_d    = err_q;
        match_d  = match_q;

        if (state_q inside {StArm, StMeasure, StLocked}) begin
            if (rise) begin
                cnt_d  = CNT_W'(1);
                hcnt_d = CNT_W'(1);
            end else begin
                if (!timeout) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (div_in && (hcnt_q != CntMax)) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
        end

        if ((state_q inside {StMeasure, StLocked}) && rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            vld_d    = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                hcnt_d = '0;
                if (en) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (rise) begin
                    state_d = StMeasure;
                end else if (timeout) begin
                    state_d  = StFault;
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                end
            end
            StMeasure: begin
                // A rise coinciding with saturation is a (mismatching) period, not a timeout.
                if (rise) begin
                    if (!cnt_ok) begin
                        match_d = '0;
                    end else if (match_q == LockV - 1'b1) begin
                        match_d  = LockV;
                        state_d  = StLocked;
                        locked_d = 1'b1;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end else if (timeout) begin
                    state_d  = StFault;
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                end
            end
            StLocked: begin
                if (rise ? !cnt_ok : timeout) begin
                    state_d  = StFault;
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                end
            end
            StFault: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!en) begin
            state_d  = StIdle;
            cnt_d    = '0;
            hcnt_d   = '0;
            period_d = period_q;
            high_d   = high_q;
            vld_d    = 1'b0;
            locked_d = 1'b0;
            err_d    = 1'b0;
            match_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            d_q      <= 1'b0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            vld_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            match_q  <= '0;
        end else begin
            state_q  <= state_d;
            d_q      <= div_in;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            vld_q    <= vld_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            match_q  <= match_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign period_vld = vld_q;
    assign locked     = locked_q;
    assign err        = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: directed div_in waveforms push hand-computed reports,
// a negedge monitor pops and compares them whenever period_vld is seen.
module tb_clk_div_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       div_in;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       period_vld;
    logic       locked;
    logic       err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] h;
        logic       lk;
        logic       er;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    clk_div_monitor #(
        .CNT_W   (8),
        .EXP_DIV (4),
        .LOCK_CNT(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_in    (div_in),
        .period    (period),
        .high_time (high_time),
        .period_vld(period_vld),
        .locked    (locked),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic step(input logic v);
        div_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic per(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1);
        for (int i = 0; i < lo; i++) step(1'b0);
    endtask

    task automatic push(input int n, input logic [7:0] p, input logic [7:0] h,
                        input logic lk, input logic er);
        for (int i = 0; i < n; i++) exp_q.push_back({p, h, lk, er});
    endtask

    // Report fields {period, high_time, locked, err} are checked together.
    always @(negedge clk) begin
        if (period_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_vld: got period=%0d high=%0d want no report",
                         period, high_time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("report", {14'b0, period, high_time, locked, err}, {14'b0, mon_e});
            end
        end
    end

    initial begin
        rst    = 1'b0;
        en     = 1'b1;
        div_in = 1'b0;

        // Reset held with div_in toggling.
        for (int i = 0; i < 6; i++) begin
            step(i % 2 == 0);
            chk("reset_outputs", {period, high_time, period_vld, locked, err}, 32'd0);
        end

        rst = 1'b1;
        step(1'b0);

        // Divide-by-4 lock: first rise arms, then reports; lock on the 3rd report.
        push(2, 8'd4, 8'd2, 1'b0, 1'b0);
        push(2, 8'd4, 8'd2, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) per(2, 2);
        chk("locked_div4", locked, 1);
        chk("err_div4", err, 0);

        // Stretched period of 5 while locked.
        push(1, 8'd4, 8'd2, 1'b1, 1'b0);
        push(1, 8'd5, 8'd2, 1'b0, 1'b1);
        per(2, 3);
        per(2, 2);
        per(2, 2);
        chk("err_sticky", err, 1);
        chk("locked_after_fault", locked, 0);

        // One cycle of en=0 clears the fault, then relock.
        en = 1'b0;
        step(1'b0);
        chk("err_cleared", err, 0);
        chk("locked_cleared", locked, 0);
        en = 1'b1;
        step(1'b0);
        push(2, 8'd4, 8'd2, 1'b0, 1'b0);
        push(2, 8'd4, 8'd2, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) per(2, 2);
        chk("relocked", locked, 1);

        // Stuck low: the last rise was 3 edges ago; fault lands 255 edges after it.
        for (int i = 0; i < 251; i++) step(1'b0);
        chk("pre_timeout_err", err, 0);
        chk("pre_timeout_locked", locked, 1);
        step(1'b0);
        chk("timeout_err", err, 1);
        chk("timeout_locked", locked, 0);

        en = 1'b0;
        step(1'b0);
        en = 1'b1;
        step(1'b0);

        // Divide-by-3 never locks; then div-4 locks so reset can be hit while locked.
        push(6, 8'd3, 8'd1, 1'b0, 1'b0);
        push(2, 8'd4, 8'd2, 1'b0, 1'b0);
        push(1, 8'd4, 8'd2, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) per(1, 2);
        for (int i = 0; i < 4; i++) per(2, 2);
        chk("locked_before_reset", locked, 1);

        rst = 1'b0;
        step(1'b1);
        chk("reset_while_locked", {period, high_time, period_vld, locked, err}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0);

        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
